// File: rtl/ihex_wb_writer_if.sv
// Pipelined wishbone bus bundle between the HEX writer (master) and the bus fabric (slave).
interface ihex_wb_writer_if #(
    parameter int unsigned AW   = 30,
    parameter int unsigned DW   = 32,
    parameter int unsigned SELW = 4
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   addr;
    logic [SELW-1:0] sel;
    logic [DW-1:0]   mosi_data;
    logic [DW-1:0]   miso_data;
    logic            stall;
    logic            ack;
    logic            err;

    modport master (
        output cyc, stb, we, addr, sel, mosi_data,
        input  stall, ack, err, miso_data
    );

    modport slave (
        input  cyc, stb, we, addr, sel, mosi_data,
        output stall, ack, err, miso_data
    );
endinterface

// File: rtl/ihex_wb_writer.sv
// Packs Intel-HEX data bytes into 32-bit words and writes them as single wishbone cycles.
// Optional ack-wait timeout enabled by defining IHEX_WB_TIMEOUT_EN.
module ihex_wb_writer #(
    parameter int unsigned AW      = 30,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte,
    input  logic [AW+1:0] i_byte_addr,
    output logic          o_byte_ready,
    input  logic          i_flush,
    output logic          o_done,
    output logic          o_busy,
    output logic          o_err,
    output logic [15:0]   o_words,
    ihex_wb_writer_if.master wb
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_ACK} state_t;

    state_t        state_q, state_d;
    logic          pending_q, pending_d;
    logic          flush_req_q, flush_req_d;
    logic [AW-1:0] word_addr_q, word_addr_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    sel_q, sel_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [15:0]   words_q, words_d;
    logic          cyc_q, cyc_d;
    logic          stb_q, stb_d;
    logic          busy_q, busy_d;

    logic [1:0]    lane;
    logic [AW-1:0] byte_word;
    logic          conflict;
    logic          accept;
    logic          finish;
    logic          fin_err;

`ifdef IHEX_WB_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    logic [TW-1:0] tmo_q;
`endif

    // Next-state, buffer merge and bus completion.
    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        flush_req_d = flush_req_q | i_flush;
        word_addr_d = word_addr_q;
        data_d      = data_q;
        sel_d       = sel_q;
        done_d      = 1'b0;
        err_d       = err_q;
        words_d     = words_q;
        finish      = 1'b0;
        fin_err     = 1'b0;

        lane         = i_byte_addr[1:0];
        byte_word    = i_byte_addr[AW+1:2];
        conflict     = (byte_word != word_addr_q) || sel_q[lane];
        o_byte_ready = (state_q == IDLE) && !(pending_q && conflict);
        accept       = i_byte_valid && o_byte_ready;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!pending_q) begin
                        word_addr_d = byte_word;
                        data_d      = '0;
                        sel_d       = '0;
                    end
                    data_d[8*lane +: 8] = i_byte;
                    sel_d[lane]         = 1'b1;
                    pending_d           = 1'b1;
                    if (sel_d == 4'hF) state_d = REQ;
                end else if (i_byte_valid && pending_q && conflict) begin
                    state_d = REQ;
                end else if (flush_req_d) begin
                    if (pending_q) begin
                        state_d = REQ;
                    end else begin
                        done_d      = 1'b1;
                        flush_req_d = 1'b0;
                    end
                end
            end
            REQ: begin
                if (!wb.stall) begin
                    if (wb.ack || wb.err) begin
                        finish  = 1'b1;
                        fin_err = wb.err;
                    end else begin
                        state_d = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                if (wb.ack || wb.err) begin
                    finish  = 1'b1;
                    fin_err = wb.err;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef IHEX_WB_TIMEOUT_EN
        if ((state_q != IDLE) && !finish && (tmo_q == TW'(TIMEOUT - 1))) begin
            finish  = 1'b1;
            fin_err = 1'b1;
        end
`endif

        // A byte still offered upstream belongs to this flush, so done waits for it.
        if (finish) begin
            state_d   = IDLE;
            pending_d = 1'b0;
            sel_d     = '0;
            if (fin_err) begin
                err_d = 1'b1;
            end else if (words_q != 16'hFFFF) begin
                words_d = words_q + 16'd1;
            end
            if (flush_req_d && !i_byte_valid) begin
                done_d      = 1'b1;
                flush_req_d = 1'b0;
            end
        end

        cyc_d  = (state_d != IDLE);
        stb_d  = (state_d == REQ);
        busy_d = pending_d || (state_d != IDLE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            flush_req_q <= 1'b0;
            word_addr_q <= '0;
            data_q      <= '0;
            sel_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            words_q     <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            flush_req_q <= flush_req_d;
            word_addr_q <= word_addr_d;
            data_q      <= data_d;
            sel_q       <= sel_d;
            done_q      <= done_d;
            err_q       <= err_d;
            words_q     <= words_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            busy_q      <= busy_d;
        end
    end

`ifdef IHEX_WB_TIMEOUT_EN
    // Cycles spent in the current bus state; restarts on every state change.
    always_ff @(posedge i_clk) begin
        if (i_reset || (state_d != state_q) || (state_q == IDLE)) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_q + TW'(1);
        end
    end
`endif

    assign wb.cyc       = cyc_q;
    assign wb.stb       = stb_q;
    assign wb.we        = cyc_q;
    assign wb.addr      = word_addr_q;
    assign wb.sel       = sel_q;
    assign wb.mosi_data = data_q;

    assign o_done  = done_q;
    assign o_busy  = busy_q;
    assign o_err   = err_q;
    assign o_words = words_q;

    // Read data is never consumed by a write-only master.
    logic unused;
    assign unused = &{1'b0, wb.miso_data, 32'(TIMEOUT)};

endmodule

// File: doc/ihex_wb_writer.md
Name: ihex_wb_writer

Overview:
Sits downstream of the Intel-HEX record parser and upstream of the wishbone bus.
- Consumes the parser's stream of data bytes, each tagged with an absolute byte address.
- Packs consecutive bytes of the same 32-bit word into one write, with accumulated byte selects.
- Issues single pipelined-wishbone write cycles as a bus master.
- On end-of-file it flushes any partial word and pulses done.

Parameters:
AW, 30, wishbone word-address width; byte address is AW+2 bits.
TIMEOUT, 1024, ack-wait limit in cycles; used only with IHEX_WB_TIMEOUT_EN.

Ports:
i_clk  input  1  clock.
i_reset  input  1  synchronous, active-high reset.
i_byte_valid  input  1  parser has a byte.
i_byte  input  8  data byte.
i_byte_addr  input  AW+2  absolute byte address of i_byte.
o_byte_ready  output  1  byte accepted on a cycle with valid&&ready.
i_flush  input  1  single-cycle pulse: EOF record seen.
o_done  output  1  one-cycle pulse once the flush has completed.
o_busy  output  1  a word is pending or a bus cycle is in flight.
o_err  output  1  sticky bus error; cleared only by reset.
o_words  output  16  count of completed (acked) writes; saturates at 16'hFFFF.
wb  interface  -  wishbone.master modport (AW, DW=32, SELW=4).
- Signals driven: stb, cyc, we, sel, addr, mosi_data.
- Signals sampled: stall, ack, err, miso_data; miso_data is unused.

Behaviour:
- Reset values:
  - Outputs: stb=0, cyc=0, we=0, sel=0, addr=0, mosi_data=0, o_done=0, o_err=0, o_words=0, o_busy=0.
  - Internal: pending=0, flush_req=0; state=IDLE.
- Lane mapping is little-endian.
  - lane = byte_addr[1:0]; word address = byte_addr[AW+1:2].
  - Byte goes to data[8*lane+:8]; sel bit [lane] is set.
- Buffer: word_addr, data, sel, pending.
- States: IDLE, REQ, WAIT_ACK.
- o_byte_ready = (state==IDLE) && !(pending && conflict).
  - conflict = byte word address differs from word_addr, OR sel[lane] is already set.
- IDLE, byte accepted:
  - If !pending: load the buffer with only this lane; pending=1.
  - Otherwise merge the lane into the buffer.
  - If the resulting sel==4'hF, go to REQ on the next cycle.
- IDLE, i_byte_valid && pending && conflict: go to REQ. The byte is held upstream and accepted after the write completes.
- i_flush: sets flush_req in any state; a flush arriving with a byte in the same cycle loses nothing.
- IDLE, flush_req set, no byte accepted this cycle:
  - If pending: go to REQ.
  - Otherwise: pulse o_done for 1 cycle and clear flush_req.
- REQ:
  - cyc=stb=we=1; addr/sel/mosi_data come from the buffer and stay stable.
  - When stall==0, the request is accepted: stb drops next cycle, go to WAIT_ACK.
  - ack or err in the same cycle as acceptance is honoured exactly as in WAIT_ACK.
- WAIT_ACK:
  - cyc=1, stb=0.
  - On ack: cyc=0, pending=0, sel=0, o_words++ (saturating), go to IDLE.
  - On err: same, but o_err=1 and o_words is not incremented.
  - ack and err together count as err.
- At most one outstanding transaction; cyc never drops between stb and ack/err.
- o_busy = pending || state!=IDLE.
- Minimum latency: byte completing a full word at cycle N → stb at N+1 → with stall=0 and ack at N+2, IDLE at N+3.
- Reset mid-cycle: cyc/stb drop at the reset edge; the pending word and flush_req are discarded.
- o_done fires only after the last write is acked or errored.

Optional Feature:
IHEX_WB_TIMEOUT_EN.
- Defined:
  - A counter runs in REQ and WAIT_ACK and is cleared on every state entry.
  - If it reaches TIMEOUT with no ack/err: cyc=stb=0, o_err=1, pending dropped, go to IDLE.
- Undefined: no counter; the block waits indefinitely for ack/err.

Test Plan:
- Bytes 11,22,33,44 at addresses 0x100..0x103, stall=0, ack 1 cycle after stb → one write: addr=0x40, sel=4'hF, data=0x44332211; o_words=1.
- Bytes AA@0x205, BB@0x206, then CC@0x300 → write addr=0x81, sel=4'b0110, data=0x00BBAA00; CC held until ack, then buffered.
- Byte 55@0x10 then i_flush → write addr=0x4, sel=4'b0001, data=0x55; o_done pulses 1 cycle after ack. i_flush with nothing pending → o_done on the next cycle, no bus cycle.
- stall held high 5 cycles in REQ → stb/addr/data stable for all 6 cycles, no extra writes. err returned instead of ack → o_err=1, o_words unchanged, next byte accepted.
- i_reset asserted during WAIT_ACK → cyc=0 the next cycle, o_busy=0; a late ack is ignored and o_words stays 0.
- With IHEX_WB_TIMEOUT_EN and TIMEOUT=8, ack never returned → cyc drops after 8 cycles, o_err=1; a following flush yields o_done.
